and_or_event_monitor: RTL

// Downstream consumer of the registered AND-OR output y. Debounces y, emits
// one-cycle rise/fall pulses and counts debounced rising events in a

---
 rtl/and_or_event_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/and_or_event_monitor.sv
// Debounces the registered AND-OR output, emits rise/fall pulses, counts debounced
// rising events in a saturating counter and exposes the count through a req/ack snapshot.
module and_or_event_monitor #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             clr,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             sat
);

    localparam int               SW      = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0]    DB_LAST = SW'(DEBOUNCE);
    localparam logic [SW-1:0]    STAB_1  = SW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        LOW,
        TO_HIGH,
        HIGH,
        TO_LOW
    } state_t;

    state_t            state;
    logic [SW-1:0]     stab;
    logic [SW-1:0]     stab_inc;
    logic              rise_set;
    logic              fall_set;
    logic [CNT_W-1:0]  count;

    // rise_set/fall_set mark the edge at which the debounced level flips
    always_comb begin
        rise_set = 1'b0;
        fall_set = 1'b0;
        stab_inc = stab + 1'b1;
        case (state)
            LOW:     rise_set = y_in && (DEBOUNCE == 1);
            TO_HIGH: rise_set = y_in && (stab_inc == DB_LAST);
            HIGH:    fall_set = !y_in && (DEBOUNCE == 1);
            TO_LOW:  fall_set = !y_in && (stab_inc == DB_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            stab  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= rise_set;
            fall <= fall_set;
            case (state)
                LOW: begin
                    if (rise_set) begin
                        state <= HIGH;
                        level <= 1'b1;
                        stab  <= '0;
                    end else if (y_in) begin
                        state <= TO_HIGH;
                        stab  <= STAB_1;
                    end
                end
                TO_HIGH: begin
                    if (!y_in) begin
                        state <= LOW;
                        stab  <= '0;
                    end else if (rise_set) begin
                        state <= HIGH;
                        level <= 1'b1;
                        stab  <= '0;
                    end else begin
                        stab <= stab_inc;
                    end
                end
                HIGH: begin
                    if (fall_set) begin
                        state <= LOW;
                        level <= 1'b0;
                        stab  <= '0;
                    end else if (!y_in) begin
                        state <= TO_LOW;
                        stab  <= STAB_1;
                    end
                end
                TO_LOW: begin
                    if (y_in) begin
                        state <= HIGH;
                        stab  <= '0;
                    end else if (fall_set) begin
                        state <= LOW;
                        level <= 1'b0;
                        stab  <= '0;
                    end else begin
                        stab <= stab_inc;
                    end
                end
                default: begin
                    state <= LOW;
                    stab  <= '0;
                end
            endcase
        end
    end

    // clr coinciding with a rise keeps that event in the fresh count
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= rise_set ? CNT_W'(1) : '0;
            sat   <= 1'b0;
        end else if (rise_set && (count != CNT_MAX)) begin
            count <= count + 1'b1;
            if (count == CNT_MAX - 1'b1)
                sat <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else if (rd_req && !rd_ack) begin
            rd_ack  <= 1'b1;
            rd_data <= count;
        end else if (!rd_req) begin
            rd_ack <= 1'b0;
        end
    end

endmodule
